// File: rtl/aftab_memory_arbiter_pkg.sv
// Shared definitions for the AFTAB memory arbiter.
// Holds the FSM state encoding, the requester index constants and the
// requester count. Requester index: 0 = debugger, 1 = data, 2 = fetch.
package aftab_memory_arbiter_pkg;

    localparam int REQ_COUNT = 3;

    typedef logic [1:0] req_idx_t;

    localparam req_idx_t DBG   = 2'd0;
    localparam req_idx_t DATA  = 2'd1;
    localparam req_idx_t FETCH = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // One-hot strobe for a requester index.
    function automatic logic [REQ_COUNT-1:0] idx_onehot(input req_idx_t i);
        return REQ_COUNT'(1) << i;
    endfunction

endpackage

// File: rtl/aftab_memory_arbiter_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears both flops
//   d   - asynchronous input
//   q   - synchronised output (two clk edges of latency)
module aftab_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aftab_memory_arbiter.sv
// Arbiter sharing one aftab_memory_segment between debugger (0), core data
// port (1) and core fetch port (2). A granted request is latched into the
// registered memory strobes; the segment's asynchronous ready is synchronised
// and turns into a one-cycle ack (with err on timeout) to the granted port.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   reqRead/reqWrite     - per-requester level requests, held until ack
//   reqAddr/reqWData     - per-requester address / write data, [i*W +: W]
//   ack/err              - one-cycle completion / timeout flags
//   rData                - last read data, held until the next read completes
//   busy                 - high whenever the FSM is not idle
//   memRead/memWrite     - registered strobes to the segment
//   memAddr/memWData     - registered address / write data to the segment
//   memRData             - read data from the segment
//   memDataReady         - segment ready, asynchronous to clk
module aftab_memory_arbiter
    import aftab_memory_arbiter_pkg::*;
#(
    parameter int dataWidth     = 8,
    parameter int addressWidth  = 32,
    parameter int timeoutCycles = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [REQ_COUNT-1:0]              reqRead,
    input  logic [REQ_COUNT-1:0]              reqWrite,
    input  logic [REQ_COUNT*addressWidth-1:0] reqAddr,
    input  logic [REQ_COUNT*dataWidth-1:0]    reqWData,
    output logic [REQ_COUNT-1:0]              ack,
    output logic [REQ_COUNT-1:0]              err,
    output logic [dataWidth-1:0]              rData,
    output logic                              busy,
    output logic                              memRead,
    output logic                              memWrite,
    output logic [addressWidth-1:0]           memAddr,
    output logic [dataWidth-1:0]              memWData,
    input  logic [dataWidth-1:0]              memRData,
    input  logic                              memDataReady
);

    localparam int CW = $clog2(timeoutCycles);
    localparam logic [CW-1:0] CNT_LAST = CW'(timeoutCycles - 1);

    arb_state_t state, state_next;

    req_idx_t       grant;
    req_idx_t       last_core;
    req_idx_t       pick;
    logic           timed_out;
    logic [CW-1:0]  cnt;
    logic           rdy_s;
    logic [REQ_COUNT-1:0] req_any;

    aftab_sync2 u_rdy_sync (
        .clk (clk),
        .rst (rst),
        .d   (memDataReady),
        .q   (rdy_s)
    );

    assign req_any = reqRead | reqWrite;

    // Debugger wins outright; data/fetch alternate, the one not served last wins.
    always_comb begin
        pick = FETCH;
        if (req_any[DBG])
            pick = DBG;
        else if (req_any[DATA] && req_any[FETCH])
            pick = (last_core == FETCH) ? DATA : FETCH;
        else if (req_any[DATA])
            pick = DATA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req_any) state_next = ACCESS;
            ACCESS:  if (rdy_s || cnt == CNT_LAST) state_next = DONE;
            DONE:    state_next = RELEASE;
            // Hold off the next grant until the previous ready is gone, so a
            // stale ready cannot complete the following access.
            RELEASE: if (!rdy_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant     <= DBG;
            last_core <= FETCH;
            timed_out <= 1'b0;
            cnt       <= '0;
            rData     <= '0;
            memRead   <= 1'b0;
            memWrite  <= 1'b0;
            memAddr   <= '0;
            memWData  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_any) begin
                        grant     <= pick;
                        memAddr   <= reqAddr[int'(pick)*addressWidth +: addressWidth];
                        memWData  <= reqWData[int'(pick)*dataWidth +: dataWidth];
                        // Read+write together is treated as a write.
                        memWrite  <= reqWrite[pick];
                        memRead   <= ~reqWrite[pick];
                        cnt       <= '0;
                        timed_out <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (rdy_s) begin
                        if (memRead) rData <= memRData;
                        memRead  <= 1'b0;
                        memWrite <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        timed_out <= 1'b1;
                        memRead   <= 1'b0;
                        memWrite  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (grant != DBG) last_core <= grant;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign ack  = (state == DONE) ? idx_onehot(grant) : '0;
    assign err  = ack & {REQ_COUNT{timed_out}};

endmodule
